jt51_lfo_multi: RTL
===================

Name: jt51_lfo_multi

Overview:
Parametrised multi-channel LFO bank, successor to the single JT51 LFO. NLFO independent phase-accumulator LFOs, each with saw/square/triangle/noise waveform and separate AM/PM depth. A shared serial shift-add scaler round-robins the channels and produces per-channel AM/PM control words for the operator pipeline. All state advances only on cen.

Parameters:
NLFO, 2, number of LFO channels (1..8)
PHW, 16, phase accumulator width per channel (>=10)
SEED, 17'h00001, LFSR reset value (must be nonzero)

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  clock
cen  in  1  clock enable; all state advances only when high
freq  in  NLFO*PHW  per-channel phase increment; ch i at [i*PHW +: PHW]
wave  in  NLFO*2  waveform: 0 saw, 1 square, 2 triangle, 3 noise
amd  in  NLFO*7  AM depth
pmd  in  NLFO*7  PM depth
sync  in  NLFO  per-channel phase restart request; may pulse on any clk
wrap  out  NLFO  one-cen pulse on phase overflow
am  out  NLFO*8  unsigned AM word per channel
pm  out  NLFO*8  sign-magnitude PM word per channel; bit7 = sign
upd  out  1  high for one cen cycle when an output word is written
upd_ch  out  3  channel written on upd
upd_pm  out  1  0 = AM written, 1 = PM written

Behaviour:
- Reset: phase=0, lfsr=SEED, am=pm=0, wrap=0, upd=0, upd_ch=0, upd_pm=0, slot=0, ch=0, sel=AM, sync latches cleared.
- sync[i] sets a latch on any clk; the latch clears on the next cen.
- Phase update per cen, per channel: if sync latch set, phase<=0, wrap=0, no LFSR step (sync wins over overflow). Else {c,phase}<=phase+freq; wrap<=c.
- freq=0 holds the phase.
- LFSR: 17-bit per channel. Steps only on wrap: lfsr<={lfsr[15:0], lfsr[16]^lfsr[13]}. It never reaches 0.
- Base values; P = phase top bits, M = P[MSB], P[MSB-1 -: 7] etc.:
  - saw: am_b = ~P[MSB-:7]; pm sign = M; pm_mag = P[MSB-1-:7].
  - square: am_b = M ? 0 : 127; pm sign = M; pm_mag = 127.
  - triangle: am_b = M ? P[MSB-1-:7] : ~P[MSB-1-:7]; pm sign = M; pm_mag = P[MSB-1] ? ~P[MSB-2-:7] : P[MSB-2-:7].
  - noise: am_b = lfsr[6:0]; pm sign = lfsr[7]; pm_mag = lfsr[6:0].
- Scaler: 3-bit slot counter, advances on cen.
  - Slot 0: latch base (am_b or pm_mag), sign and depth of current (ch, sel) from the current phase/lfsr; acc<=0.
  - Slots 1..7: if depth[slot-1], acc += base<<(slot-1). acc is 14 bits, no overflow.
  - At slot 7, from the final sum S:
    - AM: am[ch] <= S[13:6].
    - PM: pm[ch] <= (depth==0) ? 0 : {sign, S[13:7]}.
    - upd=1, upd_ch=ch, upd_pm=sel.
  - Then advance: sel AM→PM; PM→AM with ch+1, wrapping at NLFO-1→0.
- Latency: base sample to output = 8 cen. Full refresh = NLFO*16 cen.
- Depth/wave changes take effect at the next slot-0 load; an operation in progress is unaffected.
- Sync mid-operation does not disturb a latched base.
- cen low: all registers hold; upd and wrap are held low (pulses are cen-qualified).
- rst mid-operation aborts the scaler; outputs go to their reset values immediately.

Test Plan:
- Reset: assert rst asynchronously mid-operation → am=pm=0, upd=0, all phases 0, lfsr=0x00001 within the same cycle.
- Saw: ch0 saw, freq=0x1000, amd=127, cen every clk → wrap[0] pulses every 16 cen. AM sample at phase 0 → am[7:0]=0xFC (127*127>>6=252). upd order is ch0 AM, ch0 PM, ch1 AM, ch1 PM, every 8 cen.
- Square: ch1 square, pmd=127, phase≥0x8000 at load → pm[15:8]=0xFE. Same with pmd=0 → 0x00.
- Sync: ch0 freq=0x0100 at phase 0x3000; pulse sync[0] for one clk between cens → next cen phase=0x0000, no wrap, lfsr unchanged.
- Noise: ch0 noise, freq=0x8000 → lfsr steps every 2 cen: 0x00001→0x00002→0x00004. Collision check: phase=0xFF00 with sync → no step.
- Gating: hold cen low 20 clk mid-scaler → am, pm, phase and slot unchanged. Resume → next upd arrives exactly the remaining number of slots later.

Source files
------------

// File: rtl/jt51_lfo_multi_if.sv
// Control/status bundle for the multi-channel LFO bank: per-channel settings in, AM/PM words out.
interface jt51_lfo_multi_if #(
  parameter int unsigned NLFO = 2,
  parameter int unsigned PHW  = 16
);
  logic                 cen;
  logic [NLFO*PHW-1:0]  freq;
  logic [NLFO*2-1:0]    wave;
  logic [NLFO*7-1:0]    amd;
  logic [NLFO*7-1:0]    pmd;
  logic [NLFO-1:0]      sync;
  logic [NLFO-1:0]      wrap;
  logic [NLFO*8-1:0]    am;
  logic [NLFO*8-1:0]    pm;
  logic                 upd;
  logic [2:0]           upd_ch;
  logic                 upd_pm;

  modport master (
    output cen, freq, wave, amd, pmd, sync,
    input  wrap, am, pm, upd, upd_ch, upd_pm
  );

  modport slave (
    input  cen, freq, wave, amd, pmd, sync,
    output wrap, am, pm, upd, upd_ch, upd_pm
  );
endinterface

// File: rtl/jt51_lfo_multi.sv
// Bank of NLFO phase-accumulator LFOs sharing one serial shift-add depth scaler
// that round-robins channels (AM then PM) and refreshes one output word every 8 cen.
module jt51_lfo_multi #(
  parameter int unsigned NLFO = 2,
  parameter int unsigned PHW  = 16,
  parameter logic [16:0] SEED = 17'h00001
) (
  input  logic rst,
  input  logic clk,
  jt51_lfo_multi_if.slave bus
);
  localparam int unsigned MSB = PHW - 1;
  localparam int unsigned AW  = 14;

  typedef enum logic {SEL_AM = 1'b0, SEL_PM = 1'b1} sel_t;

  logic [PHW-1:0]  phase [NLFO];
  logic [16:0]     lfsr  [NLFO];
  logic [PHW:0]    sum   [NLFO];
  logic [7:0]      am_q  [NLFO];
  logic [7:0]      pm_q  [NLFO];
  logic [NLFO-1:0] sync_l;
  logic [NLFO-1:0] restart;
  logic [NLFO-1:0] wrap_q;

  logic [2:0]      slot;
  logic [2:0]      ch;
  sel_t            sel;
  logic [6:0]      base_q;
  logic [6:0]      dep_q;
  logic            sign_q;
  logic [AW-1:0]   acc;
  logic            upd_q;
  logic [2:0]      upd_ch_q;
  logic            upd_pm_q;

  logic [8:0]      ph_c;
  logic [7:0]      lf_c;
  logic [1:0]      wv_c;
  logic [6:0]      amd_c;
  logic [6:0]      pmd_c;
  logic [6:0]      am_b;
  logic [6:0]      pm_mag;
  logic [6:0]      base_c;
  logic [6:0]      dep_c;
  logic            sign_c;
  logic [2:0]      bit_c;
  logic [AW-1:0]   term_c;
  logic [AW-1:0]   sum_c;
  logic [NLFO*8-1:0] am_flat;
  logic [NLFO*8-1:0] pm_flat;

  // A sync request arriving on the cen clock itself takes effect at once
  assign restart = sync_l | bus.sync;

  always_comb begin : p_sum
    for (int i = 0; i < NLFO; i++) begin
      sum[i] = {1'b0, phase[i]} + {1'b0, bus.freq[i*PHW +: PHW]};
    end
  end

  // Phase accumulators and noise generators; sync beats overflow
  always_ff @(posedge clk or posedge rst) begin : p_phase
    if (rst) begin
      for (int i = 0; i < NLFO; i++) begin
        phase[i] <= '0;
        lfsr[i]  <= SEED;
      end
      wrap_q <= '0;
      sync_l <= '0;
    end else begin
      wrap_q <= '0;
      sync_l <= bus.cen ? '0 : (sync_l | bus.sync);
      if (bus.cen) begin
        for (int i = 0; i < NLFO; i++) begin
          if (restart[i]) begin
            phase[i] <= '0;
          end else begin
            phase[i]  <= sum[i][PHW-1:0];
            wrap_q[i] <= sum[i][PHW];
            if (sum[i][PHW]) lfsr[i] <= {lfsr[i][15:0], lfsr[i][16] ^ lfsr[i][13]};
          end
        end
      end
    end
  end

  // Waveform base value for the channel/selector about to be loaded
  always_comb begin : p_base
    ph_c  = '0;
    lf_c  = '0;
    wv_c  = '0;
    amd_c = '0;
    pmd_c = '0;
    for (int i = 0; i < NLFO; i++) begin
      if (ch == 3'(i)) begin
        ph_c  = phase[i][MSB -: 9];
        lf_c  = lfsr[i][7:0];
        wv_c  = bus.wave[i*2 +: 2];
        amd_c = bus.amd[i*7 +: 7];
        pmd_c = bus.pmd[i*7 +: 7];
      end
    end
    sign_c = ph_c[8];
    am_b   = '0;
    pm_mag = '0;
    case (wv_c)
      2'd0: begin
        am_b   = ~ph_c[8:2];
        pm_mag = ph_c[7:1];
      end
      2'd1: begin
        am_b   = ph_c[8] ? 7'd0 : 7'd127;
        pm_mag = 7'd127;
      end
      2'd2: begin
        am_b   = ph_c[8] ? ph_c[7:1] : ~ph_c[7:1];
        pm_mag = ph_c[7] ? ~ph_c[6:0] : ph_c[6:0];
      end
      default: begin
        am_b   = lf_c[6:0];
        pm_mag = lf_c[6:0];
        sign_c = lf_c[7];
      end
    endcase
    base_c = (sel == SEL_PM) ? pm_mag : am_b;
    dep_c  = (sel == SEL_PM) ? pmd_c : amd_c;
  end

  // One partial product per slot: depth bit (slot-1) weights base<<(slot-1)
  always_comb begin : p_term
    bit_c  = slot - 3'd1;
    term_c = '0;
    if (slot != 3'd0 && dep_q[bit_c]) term_c = AW'(base_q) << bit_c;
    sum_c  = acc + term_c;
  end

  always_ff @(posedge clk or posedge rst) begin : p_scaler
    if (rst) begin
      slot     <= '0;
      ch       <= '0;
      sel      <= SEL_AM;
      base_q   <= '0;
      dep_q    <= '0;
      sign_q   <= 1'b0;
      acc      <= '0;
      upd_q    <= 1'b0;
      upd_ch_q <= '0;
      upd_pm_q <= 1'b0;
      for (int i = 0; i < NLFO; i++) begin
        am_q[i] <= '0;
        pm_q[i] <= '0;
      end
    end else begin
      upd_q <= 1'b0;
      if (bus.cen) begin
        slot <= slot + 3'd1;
        if (slot == 3'd0) begin
          base_q <= base_c;
          dep_q  <= dep_c;
          sign_q <= sign_c;
          acc    <= '0;
        end else begin
          acc <= sum_c;
        end
        if (slot == 3'd7) begin
          for (int i = 0; i < NLFO; i++) begin
            if (ch == 3'(i)) begin
              if (sel == SEL_PM) pm_q[i] <= (dep_q == 7'd0) ? 8'd0 : {sign_q, sum_c[13:7]};
              else               am_q[i] <= sum_c[13:6];
            end
          end
          upd_q    <= 1'b1;
          upd_ch_q <= ch;
          upd_pm_q <= (sel == SEL_PM);
          if (sel == SEL_PM) begin
            sel <= SEL_AM;
            ch  <= (ch == 3'(NLFO - 1)) ? 3'd0 : ch + 3'd1;
          end else begin
            sel <= SEL_PM;
          end
        end
      end
    end
  end

  always_comb begin : p_flat
    am_flat = '0;
    pm_flat = '0;
    for (int i = 0; i < NLFO; i++) begin
      am_flat[i*8 +: 8] = am_q[i];
      pm_flat[i*8 +: 8] = pm_q[i];
    end
  end

  assign bus.wrap   = wrap_q;
  assign bus.am     = am_flat;
  assign bus.pm     = pm_flat;
  assign bus.upd    = upd_q;
  assign bus.upd_ch = upd_ch_q;
  assign bus.upd_pm = upd_pm_q;
endmodule
